// File: rtl/s832_pkg.sv
// Shared constants, FSM encoding and helpers for the s832 sequential stage.
// Parity support is compiled in only when S832_STATE_PARITY_EN is defined.
package s832_pkg;

   localparam int unsigned PI_W = 19;
   localparam int unsigned ST_W = 5;
   localparam int unsigned EC_W = 4;

   // State bit positions inside state_q
   localparam int unsigned G38_IDX = 0;
   localparam int unsigned G39_IDX = 1;
   localparam int unsigned G40_IDX = 2;
   localparam int unsigned G41_IDX = 3;
   localparam int unsigned G42_IDX = 4;

   localparam logic [ST_W-1:0] RST_STATE_DEF = 5'b00000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EVAL   = 3'd1,
      COMMIT = 3'd2,
      HOLD   = 3'd3,
      SCAN   = 3'd4
   } s832_seq_st_t;

   function automatic logic even_par(input logic [ST_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/s832_state_scan_reg.sv
// Five-bit s832 state register (G38..G42) with parallel load and a scan
// shift toward G42; load wins over shift.
module s832_state_scan_reg
   import s832_pkg::*;
#(
   parameter logic [ST_W-1:0] RST_STATE = RST_STATE_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [ST_W-1:0] load_val,
   input  logic            shift,
   input  logic            scan_in,
   output logic [ST_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_STATE;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {q[ST_W-2:0], scan_in};
      end
   end

endmodule

// File: rtl/s832_state_seq.sv
// Sequential stage feeding the s832 next-state cones: input capture, settle
// delay, commit of ns_in and scan access to the state flops.
// Optional state parity checking: define S832_STATE_PARITY_EN.
module s832_state_seq
   import s832_pkg::*;
#(
   parameter int unsigned     EVAL_LAT  = 1,
   parameter int unsigned     CNT_W     = 16,
   parameter logic [ST_W-1:0] RST_STATE = RST_STATE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PI_W-1:0]  pi_in,
   output logic [PI_W-1:0]  pi_q,
   output logic [ST_W-1:0]  state_q,
   input  logic [ST_W-1:0]  ns_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] step_cnt,
   input  logic             scan_en,
   input  logic             scan_in,
`ifdef S832_STATE_PARITY_EN
   input  logic             par_inj,
   output logic             state_par,
   output logic             par_err,
`endif
   output logic             scan_out
);

   localparam logic [EC_W-1:0] EVAL_LOAD = EC_W'(EVAL_LAT - 1);

   s832_seq_st_t    st;
   logic [EC_W-1:0] eval_cnt;
   logic            idle_rdy;
   logic            st_load;
   logic            st_shift;
   logic            accept;

   // idle_rdy is low during reset and the first cycle after it
   always_comb begin
      in_ready = 1'b0;
      st_load  = 1'b0;
      st_shift = 1'b0;
      if (st == IDLE) begin
         in_ready = idle_rdy & ~scan_en;
         st_shift = scan_en;
      end
      if (st == HOLD) begin
         in_ready = out_ready;
      end
      if (st == SCAN) begin
         st_shift = scan_en;
      end
      if (st == COMMIT) begin
         st_load = 1'b1;
      end
   end

   assign accept   = in_valid & in_ready;
   assign scan_out = state_q[G42_IDX];

   s832_state_scan_reg #(
      .RST_STATE (RST_STATE)
   ) u_state_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (st_load),
      .load_val (ns_in),
      .shift    (st_shift),
      .scan_in  (scan_in),
      .q        (state_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         pi_q      <= '0;
         eval_cnt  <= '0;
         step_cnt  <= '0;
         out_valid <= 1'b0;
         idle_rdy  <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (scan_en) begin
                  st       <= SCAN;
                  idle_rdy <= 1'b0;
               end else if (accept) begin
                  pi_q     <= pi_in;
                  eval_cnt <= EVAL_LOAD;
                  st       <= EVAL;
                  idle_rdy <= 1'b0;
               end else begin
                  idle_rdy <= 1'b1;
               end
            end
            EVAL: begin
               if (eval_cnt == '0) begin
                  st <= COMMIT;
               end else begin
                  eval_cnt <= eval_cnt - EC_W'(1);
               end
            end
            COMMIT: begin
               step_cnt  <= step_cnt + CNT_W'(1);
               out_valid <= 1'b1;
               st        <= HOLD;
            end
            HOLD: begin
               // Back-to-back capture skips IDLE when the consumer drains
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     pi_q     <= pi_in;
                     eval_cnt <= EVAL_LOAD;
                     st       <= EVAL;
                  end else begin
                     st       <= IDLE;
                     idle_rdy <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (!scan_en) begin
                  st       <= IDLE;
                  idle_rdy <= 1'b1;
               end
            end
            default: begin
               st        <= IDLE;
               out_valid <= 1'b0;
               idle_rdy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef S832_STATE_PARITY_EN
   logic [ST_W-1:0] shift_val;
   assign shift_val = {state_q[ST_W-2:0], scan_in};

   // Parity tracks every state_q update; par_inj corrupts it on commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_par <= even_par(RST_STATE);
         par_err   <= 1'b0;
      end else begin
         if (st_load) begin
            state_par <= even_par(ns_in) ^ par_inj;
         end else if (st_shift) begin
            state_par <= even_par(shift_val);
         end
         if (even_par(state_q) != state_par) begin
            par_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_s832_state_seq.sv
// Scoreboard bench for s832_state_seq (EVAL_LAT=1, CNT_W=4).
module tb_s832_state_seq;

   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [18:0]      pi_in;
   logic [18:0]      pi_q;
   logic [4:0]       state_q;
   logic [4:0]       ns_in;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] step_cnt;
   logic             scan_en;
   logic             scan_in;
   logic             scan_out;
`ifdef S832_STATE_PARITY_EN
   logic             par_inj;
   logic             state_par;
   logic             par_err;
`endif

   typedef struct {
      logic [4:0]       st;
      logic [CNT_W-1:0] cnt;
      logic [18:0]      pi;
   } exp_t;

   exp_t             exp_q[$];
   int               n_cmp;
   int               n_bad;
   logic [4:0]       m_state;
   logic [CNT_W-1:0] m_cnt;

   s832_state_seq #(
      .EVAL_LAT  (1),
      .CNT_W     (CNT_W),
      .RST_STATE (5'b00000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pi_in     (pi_in),
      .pi_q      (pi_q),
      .state_q   (state_q),
      .ns_in     (ns_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .step_cnt  (step_cnt),
      .scan_en   (scan_en),
      .scan_in   (scan_in),
`ifdef S832_STATE_PARITY_EN
      .par_inj   (par_inj),
      .state_par (state_par),
      .par_err   (par_err),
`endif
      .scan_out  (scan_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one input vector; caller guarantees the block is ready
   task automatic offer(input logic [18:0] pi, input logic [4:0] ns);
      exp_t e;
      in_valid = 1'b1;
      pi_in    = pi;
      ns_in    = ns;
      #1;
      check("in_ready_at_offer", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      m_cnt    = m_cnt + CNT_W'(1);
      m_state  = ns;
      e.st = ns; e.cnt = m_cnt; e.pi = pi;
      exp_q.push_back(e);
      check("pi_q_capture", 32'(pi_q), 32'(pi));
   endtask

   // Wait (bounded) for out_valid, then pop and compare the scoreboard entry
   task automatic wait_out();
      exp_t e;
      int   lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("out_valid_seen", 32'(out_valid), 32'd1);
      check("latency", 32'(lat), 32'd2);
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("state_q", 32'(state_q), 32'(e.st));
         check("step_cnt", 32'(step_cnt), 32'(e.cnt));
         check("pi_q_hold", 32'(pi_q), 32'(e.pi));
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      m_state = 5'b00000; m_cnt = '0;
      rst_n = 1'b0; in_valid = 1'b0; pi_in = '0; ns_in = '0;
      out_ready = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
`ifdef S832_STATE_PARITY_EN
      par_inj = 1'b0;
`endif
      repeat (2) tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_state", 32'(state_q), 32'd0);
      check("rst_step", 32'(step_cnt), 32'd0);
      check("rst_pi_q", 32'(pi_q), 32'd0);
      rst_n = 1'b1;
      tick();
      check("ready_after_rst", 32'(in_ready), 32'd1);

      // Single step
      offer(19'h00010, 5'b10110);
      wait_out();
      drain();
      tick();

      // Backpressure, then back-to-back acceptance from HOLD
      offer(19'h5a5a5, 5'b01101);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_state", 32'(state_q), 32'b01101);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      offer(19'h12345, 5'b11001);
      out_ready = 1'b0;
      check("b2b_out_valid", 32'(out_valid), 32'd0);
      wait_out();
      drain();
      tick();

      // Scan: old state appears MSB-first while new bits shift in
      begin
         logic [4:0] sbits;
         logic [4:0] old;
         sbits = 5'b10110;
         old   = m_state;
         scan_en = 1'b1;
         for (int i = 0; i < 5; i++) begin
            scan_in = sbits[4-i];
            #1;
            check("scan_out", 32'(scan_out), 32'(old[4-i]));
            tick();
         end
         scan_en = 1'b0;
         m_state = sbits;
         check("scan_state", 32'(state_q), 32'(m_state));
         check("scan_step", 32'(step_cnt), 32'(m_cnt));
         tick();
         check("scan_exit_ready", 32'(in_ready), 32'd1);
      end

      // Scan has priority over a simultaneous input offer
      begin
         logic [18:0] pi_before;
         pi_before = pi_q;
         scan_en  = 1'b1;
         scan_in  = 1'b1;
         in_valid = 1'b1;
         pi_in    = 19'h7ffff;
         #1;
         check("prio_in_ready", 32'(in_ready), 32'd0);
         tick();
         scan_en  = 1'b0;
         in_valid = 1'b0;
         tick();
         m_state = {m_state[3:0], 1'b1};
         check("prio_pi_q", 32'(pi_q), 32'(pi_before));
         check("prio_state", 32'(state_q), 32'(m_state));
         check("prio_step", 32'(step_cnt), 32'(m_cnt));
         tick();
      end

`ifdef S832_STATE_PARITY_EN
      check("par_clean", 32'(par_err), 32'd0);
      check("par_match", 32'(state_par), 32'(^state_q));
      par_inj = 1'b1;
      offer(19'h00f0f, 5'b00111);
      wait_out();
      par_inj = 1'b0;
      drain();
      check("par_err_set", 32'(par_err), 32'd1);
      tick();
      offer(19'h00001, 5'b00001);
      wait_out();
      drain();
      check("par_err_sticky", 32'(par_err), 32'd1);
      tick();
`endif

      // Counter wrap at 2^CNT_W committed steps
      while (m_cnt != '0) begin
         offer(19'($urandom), 5'($urandom));
         wait_out();
         drain();
         tick();
      end
      check("wrap_step", 32'(step_cnt), 32'd0);

      // Reset while holding a committed result
      offer(19'h0abcd, 5'b11111);
      wait_out();
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_state", 32'(state_q), 32'd0);
      check("midrst_step", 32'(step_cnt), 32'd0);
`ifdef S832_STATE_PARITY_EN
      check("midrst_par_err", 32'(par_err), 32'd0);
`endif
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      m_cnt = '0;
      tick();
      check("midrst_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid2", 32'(out_valid), 32'd0);

      offer(19'h00022, 5'b01010);
      wait_out();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
